// File: rtl/ddr_capture_pkg.sv
// Shared types and default sizing for the DDR sample capture controller.
package ddr_capture_pkg;

  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRETRIG  = 2'd1,
    ST_POSTTRIG = 2'd2,
    ST_DONE     = 2'd3
  } cap_state_e;

endpackage

// File: rtl/ddr_capture_ctrl_if.sv
// Capture RAM port-B write bus: the controller drives it, the RAM or a monitor consumes it.
interface ddr_capture_ctrl_if #(
  parameter int AW = 6,
  parameter int DW = 64
);
  logic [AW-1:0] ram_adr;
  logic          ram_we;
  logic [DW-1:0] ram_dat;

  modport master (output ram_adr, output ram_we, output ram_dat);
  modport slave  (input  ram_adr, input  ram_we, input  ram_dat);
endinterface

// File: rtl/ddr_capture_ctrl.sv
// Circular pre/post-trigger sample capture controller driving an external RAM write port.
module ddr_capture_ctrl
  import ddr_capture_pkg::*;
#(
  parameter int g_addr_width = ADDR_WIDTH_DEF,
  parameter int g_data_width = DATA_WIDTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    arm_i,
  input  logic                    abort_i,
  input  logic                    trig_i,
  input  logic [g_addr_width-1:0] post_cnt_i,
  input  logic                    sample_valid_i,
  input  logic [g_data_width-1:0] sample_dat_i,
  output logic [g_addr_width-1:0] ram_adr_o,
  output logic                    ram_we_o,
  output logic [g_data_width-1:0] ram_dat_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    done_p_o,
  output logic                    wrapped_o,
  output logic [g_addr_width-1:0] trig_adr_o
);

  localparam logic [g_addr_width-1:0] PTR_MAX = '1;
  localparam logic [g_addr_width-1:0] PTR_ONE = 1;
  localparam logic [g_addr_width:0]   REM_ONE = 1;

  cap_state_e              state_q, state_d;
  logic [g_addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [g_addr_width-1:0] post_cnt_q, post_cnt_d;
  logic [g_addr_width-1:0] trig_adr_q, trig_adr_d;
  logic [g_addr_width-1:0] ram_adr_q, ram_adr_d;
  logic [g_data_width-1:0] ram_dat_q, ram_dat_d;
  // One extra bit: a trigger without a sample needs post_cnt + 1 more samples.
  logic [g_addr_width:0]   remaining_q, remaining_d;
  logic [g_addr_width:0]   trig_rem;
  logic                    ram_we_q, ram_we_d;
  logic                    wrapped_q, wrapped_d;
  logic                    done_q, done_d;
  logic                    done_p_q, done_p_d;
  logic                    capturing;
  logic                    accept;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    post_cnt_d  = post_cnt_q;
    trig_adr_d  = trig_adr_q;
    ram_adr_d   = ram_adr_q;
    ram_dat_d   = ram_dat_q;
    remaining_d = remaining_q;
    ram_we_d    = 1'b0;
    wrapped_d   = wrapped_q;
    done_d      = done_q;
    done_p_d    = 1'b0;

    capturing = (state_q == ST_PRETRIG) || (state_q == ST_POSTTRIG);
    accept    = capturing && sample_valid_i && !abort_i;
    trig_rem  = {1'b0, post_cnt_q} + {{g_addr_width{1'b0}}, ~accept};

    if (accept) begin
      ram_we_d  = 1'b1;
      ram_adr_d = wr_ptr_q;
      ram_dat_d = sample_dat_i;
      wr_ptr_d  = wr_ptr_q + PTR_ONE;
      if (wr_ptr_q == PTR_MAX) wrapped_d = 1'b1;
    end

    if (abort_i) begin
      state_d     = ST_IDLE;
      wrapped_d   = 1'b0;
      done_d      = 1'b0;
      remaining_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            state_d     = ST_PRETRIG;
            wr_ptr_d    = '0;
            wrapped_d   = 1'b0;
            trig_adr_d  = '0;
            done_d      = 1'b0;
            post_cnt_d  = post_cnt_i;
            remaining_d = '0;
          end
        end
        ST_PRETRIG: begin
          if (trig_i) begin
            trig_adr_d = wr_ptr_q;
            if (trig_rem == '0) begin
              state_d     = ST_DONE;
              done_d      = 1'b1;
              done_p_d    = 1'b1;
              remaining_d = '0;
            end else begin
              state_d     = ST_POSTTRIG;
              remaining_d = trig_rem;
            end
          end
        end
        ST_POSTTRIG: begin
          if (accept) begin
            remaining_d = remaining_q - REM_ONE;
            if (remaining_q == REM_ONE) begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              done_p_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      post_cnt_q  <= '0;
      trig_adr_q  <= '0;
      ram_adr_q   <= '0;
      ram_dat_q   <= '0;
      remaining_q <= '0;
      ram_we_q    <= 1'b0;
      wrapped_q   <= 1'b0;
      done_q      <= 1'b0;
      done_p_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      post_cnt_q  <= post_cnt_d;
      trig_adr_q  <= trig_adr_d;
      ram_adr_q   <= ram_adr_d;
      ram_dat_q   <= ram_dat_d;
      remaining_q <= remaining_d;
      ram_we_q    <= ram_we_d;
      wrapped_q   <= wrapped_d;
      done_q      <= done_d;
      done_p_q    <= done_p_d;
    end
  end

  assign ram_adr_o  = ram_adr_q;
  assign ram_we_o   = ram_we_q;
  assign ram_dat_o  = ram_dat_q;
  assign busy_o     = (state_q == ST_PRETRIG) || (state_q == ST_POSTTRIG);
  assign done_o     = done_q;
  assign done_p_o   = done_p_q;
  assign wrapped_o  = wrapped_q;
  assign trig_adr_o = trig_adr_q;

endmodule
